// File: rtl/addsub_arb_pkg.sv
// Shared types for the two-requester add/sub scheduler: op bundle, lock FSM states, response tags.
package addsub_arb_pkg;

    localparam int NREQ = 2;
    localparam int OP_W = 16;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            sub;
        logic            acc;
        logic            lock;
    } addsub_op_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/addsub_rr_arbiter.sv
// Two-way round-robin arbiter with a per-requester lock that pins the grant to one owner.
module addsub_rr_arbiter
    import addsub_arb_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NREQ-1:0] valid_i,
    input  logic [NREQ-1:0] lock_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            gnt_id_o
);

    lock_state_t state_q;
    logic        ptr_q;

    always_comb begin
        gnt_o = '0;
        unique case (state_q)
            LOCKED0: gnt_o[0] = valid_i[0];
            LOCKED1: gnt_o[1] = valid_i[1];
            default: begin
                if (&valid_i) gnt_o[ptr_q] = 1'b1;
                else          gnt_o = valid_i;
            end
        endcase
        // Nothing may transfer while reset is held.
        if (Reset) gnt_o = '0;
    end

    assign gnt_id_o = gnt_o[1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= UNLOCKED;
            ptr_q   <= 1'b0;
        end else if (|gnt_o) begin
            if (lock_i[gnt_id_o]) begin
                state_q <= gnt_id_o ? LOCKED1 : LOCKED0;
            end else begin
                state_q <= UNLOCKED;
                ptr_q   <= ~gnt_id_o;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Schedules two requesters onto one pipelined add/sub datapath and routes results back by tag.
// Optional statistics counters are built when ADDSUB_ARB_STATS_EN is defined.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N   = 16,
    parameter int LAT = 2
)
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    input  logic [NREQ-1:0]   req_acc,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_z,
    output logic              rsp_ovf,
    output logic [N-1:0]      dp_A,
    output logic [N-1:0]      dp_B,
    output logic              dp_Sel,
    output logic              dp_AddSub,
    input  logic [N-1:0]      dp_Z,
    input  logic              dp_Overflow
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ops0,
    output logic [15:0]       stat_ops1,
    output logic [15:0]       stat_ovf
`endif
);

    // Op fields are OP_W wide; N is expected to equal OP_W.
    addsub_op_t      req_op [NREQ];
    logic [NREQ-1:0] gnt;
    logic            gnt_id;
    tag_t            tag_q [LAT];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[i].a    = req_a[i*N +: N];
            req_op[i].b    = req_b[i*N +: N];
            req_op[i].sub  = req_sub[i];
            req_op[i].acc  = req_acc[i];
            req_op[i].lock = req_lock[i];
        end
    end

    addsub_rr_arbiter u_arb (
        .Clock    (Clock),
        .Reset    (Reset),
        .valid_i  (req_valid),
        .lock_i   ({req_op[1].lock, req_op[0].lock}),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req_ready = gnt;

    // Issue stage: granted op drives the datapath, otherwise Z <- Z + 0 keeps the accumulator.
    always_comb begin
        dp_A      = '0;
        dp_B      = '0;
        dp_Sel    = 1'b1;
        dp_AddSub = 1'b0;
        if (|gnt) begin
            dp_A      = req_op[gnt_id].a;
            dp_B      = req_op[gnt_id].b;
            dp_Sel    = req_op[gnt_id].acc;
            dp_AddSub = req_op[gnt_id].sub;
        end
    end

    // Tag stages: follow each issued op through the datapath latency.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{valid: |gnt, id: gnt_id};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // Response stage: datapath result is passed straight to the owner.
    always_comb begin
        rsp_valid = '0;
        if (tag_q[LAT-1].valid) rsp_valid[tag_q[LAT-1].id] = 1'b1;
    end

    assign rsp_z   = dp_Z;
    assign rsp_ovf = dp_Overflow;

`ifdef ADDSUB_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_ovf  <= '0;
        end else begin
            if (rsp_valid[0])              stat_ops0 <= sat_inc(stat_ops0);
            if (rsp_valid[1])              stat_ops1 <= sat_inc(stat_ops1);
            if ((|rsp_valid) && rsp_ovf)   stat_ovf  <= sat_inc(stat_ovf);
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: external datapath model, directed scenarios and randomized traffic.
module tb_addsub_arbiter;

    localparam int N   = 16;
    localparam int LAT = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [2*N-1:0] req_a = '0;
    logic [2*N-1:0] req_b = '0;
    logic [1:0]    req_sub = '0;
    logic [1:0]    req_acc = '0;
    logic [1:0]    req_lock = '0;
    logic [1:0]    rsp_valid;
    logic [N-1:0]  rsp_z;
    logic          rsp_ovf;
    logic [N-1:0]  dp_A, dp_B;
    logic          dp_Sel, dp_AddSub;
    logic [N-1:0]  dp_Z;
    logic          dp_Overflow;
`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0]   stat_ops0, stat_ops1, stat_ovf;
`endif

    always #5 Clock = ~Clock;

    addsub_arbiter #(.N(N), .LAT(LAT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .req_acc     (req_acc),
        .req_lock    (req_lock),
        .rsp_valid   (rsp_valid),
        .rsp_z       (rsp_z),
        .rsp_ovf     (rsp_ovf),
        .dp_A        (dp_A),
        .dp_B        (dp_B),
        .dp_Sel      (dp_Sel),
        .dp_AddSub   (dp_AddSub),
        .dp_Z        (dp_Z),
        .dp_Overflow (dp_Overflow)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .stat_ops0   (stat_ops0),
        .stat_ops1   (stat_ops1),
        .stat_ovf    (stat_ovf)
`endif
    );

    // External datapath: registered inputs, registered Z/Overflow, Sel=1 feeds Z back as A.
    logic [N-1:0] dA_q, dB_q;
    logic         dSel_q, dAS_q;

    function automatic logic [N:0] dp_calc(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        logic [N-1:0] yy, r;
        yy = s ? ~y : y;
        r  = x + yy + {{(N-1){1'b0}}, s};
        return {(x[N-1] == yy[N-1]) && (r[N-1] != x[N-1]), r};
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dA_q <= '0; dB_q <= '0; dSel_q <= 1'b1; dAS_q <= 1'b0;
            dp_Z <= '0; dp_Overflow <= 1'b0;
        end else begin
            dA_q <= dp_A; dB_q <= dp_B; dSel_q <= dp_Sel; dAS_q <= dp_AddSub;
            {dp_Overflow, dp_Z} <= dp_calc(dSel_q ? dp_Z : dA_q, dB_q, dAS_q);
        end
    end

    // Checking bookkeeping and reference model state.
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int owner = -1;
    bit ptr = 1'b0;
    logic [N-1:0] acc_val = '0;
    int cnt_ops [2];
    int cnt_ovf = 0;

    typedef struct {
        int         due;
        bit         id;
        logic [N-1:0] z;
        bit         ovf;
    } exp_t;
    exp_t expq[$];

    logic [1:0]   v_s = '0, sub_s = '0, acc_s = '0, lock_s = '0;
    logic [N-1:0] a_s [2];
    logic [N-1:0] b_s [2];
    logic [1:0]   last_ready, last_rv;
    logic [N-1:0] last_z;
    logic         last_ovf;
    logic [1:0]   g [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit sub, input bit acc, input bit lock);
        v_s[i] = v; a_s[i] = a; b_s[i] = b; sub_s[i] = sub; acc_s[i] = acc; lock_s[i] = lock;
    endtask

    // One cycle: drive, compare every meaningful output against the model, advance the model.
    task automatic step();
        logic [1:0] exp_rdy;
        exp_t e;
        int i, x, y, r;
        @(negedge Clock);
        req_valid = v_s;
        req_a     = {a_s[1], a_s[0]};
        req_b     = {b_s[1], b_s[0]};
        req_sub   = sub_s;
        req_acc   = acc_s;
        req_lock  = lock_s;
        #1;
        if (owner >= 0)        exp_rdy = v_s & (2'b01 << owner);
        else if (v_s == 2'b11) exp_rdy = ptr ? 2'b10 : 2'b01;
        else                   exp_rdy = v_s;
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, 2'b01 << e.id});
            chk("rsp_z", {16'd0, rsp_z}, {16'd0, e.z});
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
            cnt_ops[e.id]++;
            if (e.ovf) cnt_ovf++;
        end else begin
            chk("rsp_valid_idle", {30'd0, rsp_valid}, 32'd0);
        end
        last_ready = req_ready; last_rv = rsp_valid; last_z = rsp_z; last_ovf = rsp_ovf;
        if (exp_rdy != 2'b00) begin
            i = exp_rdy[1] ? 1 : 0;
            chk("dp_A", {16'd0, dp_A}, {16'd0, a_s[i]});
            chk("dp_B", {16'd0, dp_B}, {16'd0, b_s[i]});
            chk("dp_ctl", {30'd0, dp_Sel, dp_AddSub}, {30'd0, acc_s[i], sub_s[i]});
            x = acc_s[i] ? int'($signed(acc_val)) : int'($signed(a_s[i]));
            y = int'($signed(b_s[i]));
            r = sub_s[i] ? x - y : x + y;
            acc_val = r[N-1:0];
            e.due = cyc + LAT; e.id = i[0]; e.z = r[N-1:0]; e.ovf = (r > 32767) || (r < -32768);
            expq.push_back(e);
            if (lock_s[i]) owner = i;
            else begin owner = -1; ptr = ~i[0]; end
        end else begin
            chk("dp_hold_AB", {dp_A, dp_B}, 32'd0);
            chk("dp_hold_ctl", {30'd0, dp_Sel, dp_AddSub}, 32'd2);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        v_s = '0;
        req_valid = '0;
        #1;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_dp_AB", {dp_A, dp_B}, 32'd0);
        chk("rst_dp_ctl", {30'd0, dp_Sel, dp_AddSub}, 32'd2);
        @(negedge Clock);
        Reset = 1'b0;
        expq.delete();
        owner = -1; ptr = 1'b0; acc_val = '0;
        cnt_ops[0] = 0; cnt_ops[1] = 0; cnt_ovf = 0;
    endtask

    function automatic logic [N-1:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin a_s[i] = '0; b_s[i] = '0; cnt_ops[i] = 0; end
        do_reset();

        // Single add from requester 0.
        set_req(0, 1, 16'd5, 16'd3, 0, 0, 0);
        step(); chk("t1_ready", {30'd0, last_ready}, 32'd1);
        v_s = '0; step(); step();
        chk("t1_rv", {30'd0, last_rv}, 32'd1);
        chk("t1_z", {16'd0, last_z}, 32'd8);
        chk("t1_ovf", {31'd0, last_ovf}, 32'd0);

        // Subtract overflow from requester 1.
        set_req(1, 1, 16'h8000, 16'h0001, 1, 0, 0);
        step(); chk("t2_ready", {30'd0, last_ready}, 32'd2);
        v_s = '0; step(); step();
        chk("t2_rv", {30'd0, last_rv}, 32'd2);
        chk("t2_z", {16'd0, last_z}, 32'h7FFF);
        chk("t2_ovf", {31'd0, last_ovf}, 32'd1);

        // Both requesters continuously valid: grants alternate starting at 0.
        set_req(0, 1, 16'd100, 16'd1, 0, 0, 0);
        set_req(1, 1, 16'd200, 16'd2, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            g[k] = last_ready;
            if (last_ready[0]) set_req(0, 1, N'(k*3+1), N'(k+7), k[0], 0, 0);
            if (last_ready[1]) set_req(1, 1, N'(k*5+2), N'(k+9), ~k[0], 0, 0);
        end
        for (int k = 0; k < 8; k++) chk("t3_grant", {30'd0, g[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
        v_s = '0; step(); step();

        // Accumulate chain, then accumulate after idle cycles.
        set_req(0, 1, 16'd10, 16'd0, 0, 0, 0); step();
        set_req(0, 1, 16'hDEAD, 16'd5, 0, 1, 0); step();
        set_req(0, 1, 16'd0, 16'd3, 1, 1, 0); step();
        chk("t4_z0", {16'd0, last_z}, 32'd10);
        v_s = '0; step(); chk("t4_z1", {16'd0, last_z}, 32'd15);
        step(); chk("t4_z2", {16'd0, last_z}, 32'd12);
        step();
        set_req(0, 1, 16'd0, 16'd1, 0, 1, 0); step();
        v_s = '0; step(); step();
        chk("t4_rv3", {30'd0, last_rv}, 32'd1);
        chk("t4_z3", {16'd0, last_z}, 32'd13);

        // Lock: requester 1 waits while requester 0 owns the datapath.
        set_req(1, 1, 16'd100, 16'd1, 0, 0, 0); step();
        chk("t5_pre", {30'd0, last_ready}, 32'd2);
        set_req(1, 1, 16'd200, 16'd2, 0, 0, 0);
        set_req(0, 1, 16'd7, 16'd7, 0, 0, 1); step();
        chk("t5_lock", {30'd0, last_ready}, 32'd1);
        v_s[0] = 1'b0; step(); chk("t5_idle0", {30'd0, last_ready}, 32'd0);
        step(); chk("t5_idle1", {30'd0, last_ready}, 32'd0);
        set_req(0, 1, 16'd9, 16'd9, 0, 0, 0); step();
        chk("t5_unlock", {30'd0, last_ready}, 32'd1);
        v_s[0] = 1'b0; step(); chk("t5_req1", {30'd0, last_ready}, 32'd2);
        v_s = '0; step(); step();

        // Reset while an op is in flight and requester 0 holds the lock.
        set_req(0, 1, 16'd20, 16'd22, 0, 0, 1); step();
        v_s = '0;
        do_reset();
        step(); chk("t6_norsp0", {30'd0, last_rv}, 32'd0);
        step(); chk("t6_norsp1", {30'd0, last_rv}, 32'd0);
        set_req(0, 1, 16'd1, 16'd1, 0, 0, 0);
        set_req(1, 1, 16'd2, 16'd2, 0, 0, 0);
        step(); chk("t6_first", {30'd0, last_ready}, 32'd1);
        v_s[0] = 1'b0; step(); chk("t6_second", {30'd0, last_ready}, 32'd2);
        v_s = '0; step(); step();

        // Randomized traffic with stable fields until transfer.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v_s[i] || last_ready[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, rnd16(), rnd16(), $urandom_range(0, 1) == 1,
                            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
                end
            end
            step();
        end
        v_s = '0;
        repeat (LAT + 1) step();
        chk("drain_empty", expq.size(), 32'd0);
`ifdef ADDSUB_ARB_STATS_EN
        chk("stat_ops0", {16'd0, stat_ops0}, (cnt_ops[0] > 65535) ? 32'hFFFF : cnt_ops[0]);
        chk("stat_ops1", {16'd0, stat_ops1}, (cnt_ops[1] > 65535) ? 32'hFFFF : cnt_ops[1]);
        chk("stat_ovf", {16'd0, stat_ovf}, (cnt_ovf > 65535) ? 32'hFFFF : cnt_ovf);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Two-requester scheduler that shares one pipelined n-bit adder/subtractor datapath: registered A/B/Sel/AddSub inputs, registered Z/Overflow outputs, Sel=1 feeds Z back in place of A.
- Round-robin arbitration with a per-requester lock, so a requester can own the feedback path for accumulate sequences.
- Issues at most one op per cycle, tracks in-flight ops by tag, routes each result back to its owner after a fixed latency.

Parameters:
- N, 16, operand/result width; must match the datapath n.
- LAT, 2, datapath latency in cycles from dp_* drive to dp_Z/dp_Overflow valid; must be ≥1.

Ports:
- Clock  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  grant/accept, bit i = requester i
- req_a  in  2*N  operand A, slice [i*N +: N]
- req_b  in  2*N  operand B, slice [i*N +: N]
- req_sub  in  2  1 = subtract, 0 = add
- req_acc  in  2  1 = accumulate (A ignored, uses previous result)
- req_lock  in  2  hold grant for this requester after this op
- rsp_valid  out  2  one-cycle result strobe per requester
- rsp_z  out  N  result
- rsp_ovf  out  1  signed overflow of result
- dp_A  out  N  datapath A
- dp_B  out  N  datapath B
- dp_Sel  out  1  datapath Sel
- dp_AddSub  out  1  datapath AddSub
- dp_Z  in  N  datapath Z
- dp_Overflow  in  1  datapath Overflow

Behaviour:
- Reset: Clock domain is Clock; Reset is asynchronous and active-high.
  - Reset values: req_ready=0, rsp_valid=0, rr pointer=0, lock state UNLOCKED, tag pipeline cleared.
  - dp_* outputs are set to the hold pattern.
- Hold pattern: dp_A=0, dp_B=0, dp_Sel=1, dp_AddSub=0, giving Z←Z+0.
  - Driven on every non-issue cycle so the accumulator value survives idle cycles.
  - Never drive Sel=0 with zero operands while idle.
- Transfer: occurs when req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, the pointer and the lock state.
  - At most one bit of req_ready is set per cycle.
  - A requester may assert valid without waiting for ready. Its fields must stay stable until the transfer.
- Issue (same cycle as the transfer, combinational):
  - dp_A=a, dp_B=b, dp_AddSub=sub, dp_Sel=acc.
  - acc=1 gives result = previous datapath result ± b. "Previous" means the op issued one cycle earlier, or the held value.
  - Back-to-back accumulates chain correctly at one op per cycle.
- Response:
  - Transfer in cycle t gives rsp_valid[i]=1 in cycle t+LAT.
  - rsp_z=dp_Z and rsp_ovf=dp_Overflow (pass-through) in that cycle.
  - Tag pipeline: LAT-deep shift register of {valid, id}.
  - No response backpressure; the requester must accept.
  - rsp_z/rsp_ovf are don't-care when rsp_valid=0.
- Arbitration, UNLOCKED:
  - If both requesters are valid, grant the one the pointer selects. If one is valid, grant it.
  - After a grant to i, pointer = 1-i.
- Lock FSM:
  - UNLOCKED → LOCKEDi on a transfer from i with req_lock[i]=1.
  - In LOCKEDi only requester i may be granted. Other requesters wait even if i is idle; the hold pattern is driven meanwhile.
  - LOCKEDi → UNLOCKED on a transfer from i with req_lock[i]=0.
  - The pointer is not updated while locked. It is set to 1-i on the unlocking transfer.
- Arithmetic: N-bit two's complement, wraps mod 2^N. Overflow is signed overflow as reported by the datapath.
- Reset mid-operation: in-flight ops are discarded with no rsp_valid, and any lock is released. The datapath shares Reset, so Z=0 after reset.

Optional Feature:
- Macro: ADDSUB_ARB_STATS_EN.
- Defined: adds outputs stat_ops0 and stat_ops1 (16-bit completed-op counts per requester) and stat_ovf (16-bit count of rsp_ovf=1 responses).
  - Counters increment on rsp_valid and saturate at 0xFFFF.
  - Reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package addsub_arb_pkg:
  - NREQ=2.
  - Typedef struct addsub_op_t {a, b, sub, acc, lock}.
  - Enum lock_state_t {UNLOCKED, LOCKED0, LOCKED1}.
  - Typedef tag_t {valid, id}.
- Sub-module addsub_rr_arbiter: 2-way round-robin with lock FSM. Outputs the grant vector and the grant id.
- The tag pipeline and dp muxing stay in the top level.

Test Plan:
- Release reset; req0 add a=5 b=3 → req_ready[0]=1 the same cycle; rsp_valid[0] 2 cycles later with rsp_z=8, rsp_ovf=0; dp_Sel=1/dp_B=0 on every other cycle.
- req1 sub a=0x8000 b=0x0001 → rsp_z=0x7FFF, rsp_ovf=1, rsp_valid[1] only.
- Both requesters valid continuously with distinct operands → grants alternate 0,1,0,1 starting at 0; responses arrive one per cycle in the same order with correct values.
- req0 back-to-back: a=10 b=0 add, then acc b=5 add, then acc b=3 sub → rsp_z 10, 15, 12. After 3 idle cycles, acc b=1 add → 13.
- Lock:
  - req0 issues lock=1 while req1 is valid → req1 ready stays 0.
  - req0 idles 2 cycles → no grants.
  - req0 issues lock=0 → req1 is granted the next cycle.
- Mid-flight reset: transfer at t, Reset pulsed at t+1 → no rsp_valid. After release with both requesters valid, the first grant goes to req0 and the lock is UNLOCKED.
